ecc_scrub_ctrl: RTL and testbench
=================================

ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 64, data word width
  ADDR_W, 14, memory address width
  DEPTH, 16384, words swept per pass
  GAP, 256, idle clk cycles between scrub reads (1..65535)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all logic rising-edge
  rst  in  1  asynchronous, active-high reset
  host_w_en / host_w_addr / host_w_data  in  1/ADDR_W/DATA_W  host write request
  host_r_en / host_r_addr  in  1/ADDR_W  host read request
  mem_w_en / mem_w_addr / mem_w_data  out  1/ADDR_W/DATA_W  to ECC memory write port
  mem_r_en / mem_r_addr  out  1/ADDR_W  to ECC memory read port
  mem_r_data  in  DATA_W  corrected read data from ECC memory
  mem_sgl / mem_dbl  in  1/1  single-bit corrected / double-bit detected flags
  scrub_en  in  1  enables sweeping
  clr_cnt  in  1  synchronous clear of counters and log
  busy  out  1  scrub access in flight (RD, CHK or WB)
  sgl_cnt / dbl_cnt  out  16/16  saturating error counters
  dbl_valid / dbl_addr  out  1/ADDR_W  first double-error address log
  pass_done  out  1  one-cycle pulse at end of each full sweep

Function
REQ-003 Memory read latency SHALL be 1: mem_r_data/mem_sgl/mem_dbl sample the cycle after mem_r_en.
REQ-004 Host requests SHALL pass combinationally to mem_* ports and always take priority over scrub accesses on the same port.
REQ-005 FSM states SHALL be IDLE, GAP, RD, CHK, WB.
REQ-006 IDLE -> GAP when scrub_en=1; any state -> IDLE when scrub_en=0, except WB, which completes first.
REQ-007 GAP SHALL count GAP cycles, then -> RD.
REQ-008 RD SHALL drive mem_r_en=1, mem_r_addr=scrub pointer when host_r_en=0; otherwise stall in RD.
REQ-009 CHK SHALL sample flags: mem_dbl=1 -> dbl_cnt+1, log address if dbl_valid=0, -> GAP; mem_sgl=1 -> sgl_cnt+1, latch mem_r_data, -> WB; neither -> GAP.
REQ-010 mem_dbl SHALL take precedence when both flags assert.
REQ-011 WB SHALL write latched data to pointer address when host_w_en=0; stall otherwise.
REQ-012 Host write to the pending WB address while in CHK or WB SHALL cancel writeback (no mem write), -> GAP.
REQ-013 Scrub pointer SHALL advance on leaving CHK/WB; wrap DEPTH-1 -> 0 with pass_done=1 that cycle.
REQ-014 Counters SHALL saturate at 16'hFFFF; clr_cnt clears counters, dbl_valid, dbl_addr; clr_cnt coincident with error: clear wins.
REQ-015 Only scrub reads SHALL affect counters; host-read flags are ignored.

Reset
REQ-016 rst SHALL force IDLE, pointer=0, GAP counter=0, all counters 0, dbl_valid=0, dbl_addr=0, pass_done=0, busy=0, scrub mem enables 0.
REQ-017 rst mid-WB SHALL abandon the write immediately.

Configuration
REQ-018 With SCRUB_WRITEBACK_EN defined, REQ-011/012 apply; without it, mem_sgl in CHK SHALL count only and go to GAP, WB state absent.

Structure
REQ-019 Package ecc_scrub_pkg SHALL hold state enum, default widths, counter width 16.
REQ-020 Sub-module ecc_port_arb SHALL implement host/scrub muxing for both ports.

Verification
REQ-021 GAP=4, scrub_en=1, no errors -> read addr 0,1,2,... every 6 cycles; pass_done after DEPTH-1.
REQ-022 Inject mem_sgl at addr 5, data 64'd10 -> sgl_cnt=1, mem_w_en at addr 5 data 10 next cycle.
REQ-023 mem_dbl at addr 7 then addr 9 -> dbl_cnt=2, dbl_addr=7, dbl_valid=1, no writeback.
REQ-024 host_w_en addr 5 in CHK with sgl -> no scrub write; host data retained.
REQ-025 host_r_en held 3 cycles during RD -> scrub read delayed 3 cycles, same address.
REQ-026 rst pulse in WB; SCRUB_WRITEBACK_EN undefined rerun REQ-022 -> sgl_cnt=1, mem_w_en never asserted.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types and constants for the ECC scrub controller.
// The state list depends on SCRUB_WRITEBACK_EN: the WB state exists only
// when correctable words are written back.
package ecc_scrub_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 14;
  localparam int DEPTH_DEF  = 16384;
  localparam int GAP_DEF    = 256;
  localparam int CNT_W      = 16;
  localparam int GAP_CNT_W  = 16;

`ifdef SCRUB_WRITEBACK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_GAP, ST_RD, ST_CHK, ST_WB} scrub_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_GAP, ST_RD, ST_CHK} scrub_state_t;
`endif

  // Saturating increment for the error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ecc_port_arb.sv
// Host/scrub multiplexer for the memory read and write ports.
// Host requests always win; the scrub FSM never issues while the host
// holds the same port, so a host request simply overrides the mux.
module ecc_port_arb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14
) (
  input  logic              host_w_en,
  input  logic [ADDR_W-1:0] host_w_addr,
  input  logic [DATA_W-1:0] host_w_data,
  input  logic              host_r_en,
  input  logic [ADDR_W-1:0] host_r_addr,
  input  logic              scrub_w_en,
  input  logic [ADDR_W-1:0] scrub_w_addr,
  input  logic [DATA_W-1:0] scrub_w_data,
  input  logic              scrub_r_en,
  input  logic [ADDR_W-1:0] scrub_r_addr,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr
);

  // Write port: host first, scrub writeback otherwise.
  always_comb begin
    mem_w_en   = host_w_en | scrub_w_en;
    mem_w_addr = scrub_w_addr;
    mem_w_data = scrub_w_data;
    if (host_w_en) begin
      mem_w_addr = host_w_addr;
      mem_w_data = host_w_data;
    end
  end

  // Read port: host first, scrub read otherwise.
  always_comb begin
    mem_r_en   = host_r_en | scrub_r_en;
    mem_r_addr = scrub_r_addr;
    if (host_r_en) mem_r_addr = host_r_addr;
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: sweeps the memory one word every GAP+2 cycles,
// counts single/double errors, logs the first double-error address.
// Define SCRUB_WRITEBACK_EN to write corrected data back on single errors.
//
// state | meaning
// IDLE  | sweeping disabled
// GAP   | idle spacing between scrub reads (GAP cycles)
// RD    | issue scrub read at pointer (stalls while host reads)
// CHK   | inspect ECC flags of the scrub read
// WB    | write corrected word back (stalls while host writes)
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_w_en,
  input  logic [ADDR_W-1:0] host_w_addr,
  input  logic [DATA_W-1:0] host_w_data,
  input  logic              host_r_en,
  input  logic [ADDR_W-1:0] host_r_addr,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_sgl,
  input  logic              mem_dbl,
  input  logic              scrub_en,
  input  logic              clr_cnt,
  output logic              busy,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt,
  output logic              dbl_valid,
  output logic [ADDR_W-1:0] dbl_addr,
  output logic              pass_done
);

  localparam logic [ADDR_W-1:0]    LP_LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [GAP_CNT_W-1:0] LP_GAP_LOAD = GAP_CNT_W'(GAP - 1);

  scrub_state_t          r_state, w_next;
  logic [ADDR_W-1:0]     r_ptr;
  logic [GAP_CNT_W-1:0]  r_gap_cnt;
  logic [CNT_W-1:0]      r_sgl_cnt, r_dbl_cnt;
  logic                  r_dbl_valid;
  logic [ADDR_W-1:0]     r_dbl_addr;
  logic                  w_scrub_r_en, w_scrub_w_en, w_advance;
  logic                  w_cnt_sgl, w_cnt_dbl;
  logic [DATA_W-1:0]     w_scrub_w_data;

`ifdef SCRUB_WRITEBACK_EN
  logic [DATA_W-1:0]     r_wb_data;
  logic                  w_latch, w_wb_hit;
  assign w_wb_hit       = host_w_en && (host_w_addr == r_ptr);
  assign w_scrub_w_data = r_wb_data;
`else
  // Corrected data is not needed when writeback is compiled out.
  logic                  w_unused_rdata;
  assign w_unused_rdata = ^mem_r_data;
  assign w_scrub_w_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and scrub port requests.
  always_comb begin
    w_next       = r_state;
    w_scrub_r_en = 1'b0;
    w_scrub_w_en = 1'b0;
    w_advance    = 1'b0;
    w_cnt_sgl    = 1'b0;
    w_cnt_dbl    = 1'b0;
`ifdef SCRUB_WRITEBACK_EN
    w_latch      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (scrub_en) w_next = ST_GAP;
      ST_GAP: begin
        if (!scrub_en)            w_next = ST_IDLE;
        else if (r_gap_cnt == '0) w_next = ST_RD;
      end
      ST_RD: begin
        if (!scrub_en) w_next = ST_IDLE;
        else if (!host_r_en) begin
          w_scrub_r_en = 1'b1;
          w_next       = ST_CHK;
        end
      end
      ST_CHK: begin
        // The read already happened, so flags are counted even when
        // sweeping is being switched off; only the writeback is dropped.
        w_advance = 1'b1;
        w_next    = scrub_en ? ST_GAP : ST_IDLE;
        if (mem_dbl) w_cnt_dbl = 1'b1;
        else if (mem_sgl) begin
          w_cnt_sgl = 1'b1;
`ifdef SCRUB_WRITEBACK_EN
          // A host write to the same word makes the corrected copy stale.
          if (scrub_en && !w_wb_hit) begin
            w_advance = 1'b0;
            w_latch   = 1'b1;
            w_next    = ST_WB;
          end
`endif
        end
      end
`ifdef SCRUB_WRITEBACK_EN
      ST_WB: begin
        if (w_wb_hit) begin
          w_advance = 1'b1;
          w_next    = scrub_en ? ST_GAP : ST_IDLE;
        end else if (!host_w_en) begin
          w_scrub_w_en = 1'b1;
          w_advance    = 1'b1;
          w_next       = scrub_en ? ST_GAP : ST_IDLE;
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Gap down-counter, loaded on every entry into GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gap_cnt <= '0;
    else if (w_next == ST_GAP && r_state != ST_GAP) r_gap_cnt <= LP_GAP_LOAD;
    else if (r_state == ST_GAP && r_gap_cnt != '0)  r_gap_cnt <= r_gap_cnt - 1'b1;
  end

  // Scrub pointer, wraps after the last swept word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_advance) r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
  end

`ifdef SCRUB_WRITEBACK_EN
  // Hold the corrected word for the writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_wb_data <= '0;
    else if (w_latch) r_wb_data <= mem_r_data;
  end
`endif

  // Error counters and first double-error log; clear beats a same-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr_cnt) begin
      r_sgl_cnt   <= '0;
      r_dbl_cnt   <= '0;
      r_dbl_valid <= 1'b0;
      r_dbl_addr  <= '0;
    end else begin
      if (w_cnt_sgl) r_sgl_cnt <= sat_inc(r_sgl_cnt);
      if (w_cnt_dbl) begin
        r_dbl_cnt <= sat_inc(r_dbl_cnt);
        if (!r_dbl_valid) begin
          r_dbl_valid <= 1'b1;
          r_dbl_addr  <= r_ptr;
        end
      end
    end
  end

  assign sgl_cnt   = r_sgl_cnt;
  assign dbl_cnt   = r_dbl_cnt;
  assign dbl_valid = r_dbl_valid;
  assign dbl_addr  = r_dbl_addr;
  assign pass_done = w_advance && (r_ptr == LP_LAST);
`ifdef SCRUB_WRITEBACK_EN
  assign busy = (r_state == ST_RD) || (r_state == ST_CHK) || (r_state == ST_WB);
`else
  assign busy = (r_state == ST_RD) || (r_state == ST_CHK);
`endif

  ecc_port_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_arb (
    .host_w_en    (host_w_en),
    .host_w_addr  (host_w_addr),
    .host_w_data  (host_w_data),
    .host_r_en    (host_r_en),
    .host_r_addr  (host_r_addr),
    .scrub_w_en   (w_scrub_w_en),
    .scrub_w_addr (r_ptr),
    .scrub_w_data (w_scrub_w_data),
    .scrub_r_en   (w_scrub_r_en),
    .scrub_r_addr (r_ptr),
    .mem_w_en     (mem_w_en),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data),
    .mem_r_en     (mem_r_en),
    .mem_r_addr   (mem_r_addr)
  );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a small ECC memory model.
module tb_ecc_scrub_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16;
  localparam int GAP    = 4;
`ifdef SCRUB_WRITEBACK_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              host_w_en, host_r_en;
  logic [ADDR_W-1:0] host_w_addr, host_r_addr;
  logic [DATA_W-1:0] host_w_data;
  logic              mem_w_en, mem_r_en;
  logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data = '0;
  logic              mem_sgl = 1'b0, mem_dbl = 1'b0;
  logic              scrub_en, clr_cnt;
  logic              busy, dbl_valid, pass_done;
  logic [15:0]       sgl_cnt, dbl_cnt;
  logic [ADDR_W-1:0] dbl_addr;

  ecc_scrub_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .host_w_en(host_w_en), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
    .host_r_en(host_r_en), .host_r_addr(host_r_addr),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data), .mem_sgl(mem_sgl), .mem_dbl(mem_dbl),
    .scrub_en(scrub_en), .clr_cnt(clr_cnt), .busy(busy),
    .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt), .dbl_valid(dbl_valid),
    .dbl_addr(dbl_addr), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words return a fixed pattern; flags come from
  // per-address injection tables, one cycle after the read.
  logic [DATA_W-1:0] mem [256];
  bit                mem_valid [256];
  bit                sgl_inj [256];
  bit                dbl_inj [256];
  int                cyc;
  int                scrub_wr;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    case (a)
      5:       return 64'd10;
      2:       return 64'd55;
      default: return 64'(a * 3);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] model_word(input int a);
    return mem_valid[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_r_en) begin
      mem_r_data <= model_word(int'(mem_r_addr[7:0]));
      mem_sgl    <= sgl_inj[mem_r_addr[7:0]];
      mem_dbl    <= dbl_inj[mem_r_addr[7:0]];
    end else begin
      mem_sgl <= 1'b0;
      mem_dbl <= 1'b0;
    end
    if (mem_w_en) begin
      mem[mem_w_addr[7:0]]       <= mem_w_data;
      mem_valid[mem_w_addr[7:0]] <= 1'b1;
    end
    if (mem_w_en && !host_w_en) scrub_wr <= scrub_wr + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_r_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_read timeout actual=none required=scrub_read");
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_busy timeout actual=0 required=1");
    end
  endtask

  typedef struct {
    int          addr;
    int          gap;
    bit          sgl_wr;
    bit          pdone;
    logic [15:0] sgl;
    logic [15:0] dbl;
  } vec_t;

  vec_t vt [17];

  initial begin
    bit ok;
    int prev, c0;

    // Sweep table: read address, cycles since previous scrub read,
    // writeback expected, pass_done in CHK, counters after the word.
    for (int i = 0; i < 17; i++) begin
      vt[i].addr = i % DEPTH; vt[i].gap = 6; vt[i].sgl_wr = 1'b0;
      vt[i].pdone = 1'b0;     vt[i].sgl = 16'd0; vt[i].dbl = 16'd0;
    end
    vt[5].sgl_wr = WB_ON;  vt[5].sgl = 16'd1;
    vt[6].gap    = WB_ON ? 7 : 6;  vt[6].sgl = 16'd1;
    vt[7].sgl = 16'd1;  vt[7].dbl = 16'd1;
    vt[8].sgl = 16'd1;  vt[8].dbl = 16'd1;
    for (int i = 9; i < 17; i++) begin
      vt[i].sgl = 16'd1; vt[i].dbl = 16'd2;
    end
    vt[15].pdone = 1'b1;

    sgl_inj[5] = 1'b1;
    dbl_inj[7] = 1'b1;
    dbl_inj[9] = 1'b1;
    sgl_inj[9] = 1'b1;   // both flags: double must win

    rst = 1'b1; scrub_en = 1'b0; clr_cnt = 1'b0;
    host_w_en = 1'b0; host_r_en = 1'b0;
    host_w_addr = '0; host_r_addr = '0; host_w_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_r_en", 64'(mem_r_en), 64'd0);
    chk("rst_w_en", 64'(mem_w_en), 64'd0);
    chk("rst_sgl_cnt", 64'(sgl_cnt), 64'd0);
    chk("rst_dbl_valid", 64'(dbl_valid), 64'd0);
    chk("rst_pass_done", 64'(pass_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full sweep plus the wrap back to address 0.
    scrub_en = 1'b1;
    prev = 0;
    for (int i = 0; i < 17; i++) begin
      wait_read(ok);
      chk("sweep_addr", 64'(mem_r_addr), 64'(vt[i].addr));
      if (i > 0) chk("sweep_interval", 64'(cyc - prev), 64'(vt[i].gap));
      prev = cyc;
      @(negedge clk);
      chk("sweep_pass_done", 64'(pass_done), 64'(vt[i].pdone));
      chk("sweep_chk_no_wr", 64'(mem_w_en), 64'd0);
      if (i == 16) scrub_en = 1'b0;
      if (vt[i].sgl_wr) begin
        @(negedge clk);
        chk("wb_en", 64'(mem_w_en), 64'd1);
        chk("wb_addr", 64'(mem_w_addr), 64'd5);
        chk("wb_data", mem_w_data, 64'd10);
      end
      @(negedge clk);
      chk("sweep_sgl_cnt", 64'(sgl_cnt), 64'(vt[i].sgl));
      chk("sweep_dbl_cnt", 64'(dbl_cnt), 64'(vt[i].dbl));
    end
    chk("dbl_addr", 64'(dbl_addr), 64'd7);
    chk("dbl_valid", 64'(dbl_valid), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("sweep_scrub_wr", 64'(scrub_wr), 64'(WB_ON ? 1 : 0));

    // Counter clear.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_sgl_cnt", 64'(sgl_cnt), 64'd0);
    chk("clr_dbl_cnt", 64'(dbl_cnt), 64'd0);
    chk("clr_dbl_valid", 64'(dbl_valid), 64'd0);
    chk("clr_dbl_addr", 64'(dbl_addr), 64'd0);

    // Host read holds the read port for 3 cycles during RD; its flags are ignored.
    sgl_inj[100] = 1'b1;
    host_r_addr = ADDR_W'(100);
    scrub_en = 1'b1;
    wait_busy(ok);
    chk("stall_first_addr", 64'(mem_r_addr), 64'd1);
    host_r_en = 1'b1;
    c0 = cyc;
    repeat (3) begin
      @(negedge clk);
      chk("stall_host_addr", 64'(mem_r_addr), 64'd100);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    host_r_en = 1'b0;
    #1;
    chk("stall_scrub_en", 64'(mem_r_en), 64'd1);
    chk("stall_scrub_addr", 64'(mem_r_addr), 64'd1);
    chk("stall_delay", 64'(cyc - c0), 64'd3);
    repeat (2) @(negedge clk);
    chk("host_flags_ignored", 64'(sgl_cnt), 64'd0);

    // Host write to the pending word during CHK cancels the writeback.
    sgl_inj[2] = 1'b1;
    wait_read(ok);
    chk("cancel_rd_addr", 64'(mem_r_addr), 64'd2);
    @(negedge clk);
    host_w_en = 1'b1; host_w_addr = ADDR_W'(2); host_w_data = 64'd77;
    @(negedge clk);
    host_w_en = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_sgl_cnt", 64'(sgl_cnt), 64'd1);
    chk("cancel_host_data", model_word(2), 64'd77);
    @(negedge clk);
    chk("cancel_no_wr", 64'(mem_w_en), 64'd0);
    chk("cancel_scrub_wr", 64'(scrub_wr), 64'(WB_ON ? 1 : 0));

`ifdef SCRUB_WRITEBACK_EN
    // Reset in the middle of a writeback abandons it at once.
    sgl_inj[3] = 1'b1;
    wait_read(ok);
    chk("rstwb_rd_addr", 64'(mem_r_addr), 64'd3);
    @(negedge clk);
    @(negedge clk);
    chk("rstwb_w_en", 64'(mem_w_en), 64'd1);
    chk("rstwb_w_addr", 64'(mem_w_addr), 64'd3);
    rst = 1'b1;
    #1;
    chk("rstwb_w_dropped", 64'(mem_w_en), 64'd0);
    chk("rstwb_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwb_no_write", 64'(mem_valid[3]), 64'd0);
    chk("rstwb_scrub_wr", 64'(scrub_wr), 64'd1);
`else
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("nowb_scrub_wr", 64'(scrub_wr), 64'd0);
`endif
    chk("post_rst_sgl_cnt", 64'(sgl_cnt), 64'd0);

    // clr_cnt in the same cycle as a double error: clear wins.
    dbl_inj[0] = 1'b1;
    wait_read(ok);
    chk("clrwin_rd_addr", 64'(mem_r_addr), 64'd0);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clrwin_dbl_cnt", 64'(dbl_cnt), 64'd0);
    chk("clrwin_dbl_valid", 64'(dbl_valid), 64'd0);
    scrub_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
